// File: rtl/fixed_point_quotient_decimator_if.sv
// Valid/ready bus between the long divider, the quotient decimator and the next DSP stage.
interface fixed_point_quotient_decimator_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fixed_point_quotient_decimator.sv
// Averages each block of 2**LOG2_DECIM quotient samples into one rounded or truncated mean,
// held in a single output register behind a valid/ready handshake.
module fixed_point_quotient_decimator #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DECIM = 2,
    parameter int ROUND      = 1
) (
    input logic                           clk,
    input logic                           reset_n,
    fixed_point_quotient_decimator_if.slave bus
);
    localparam int ACC_W     = DATA_W + LOG2_DECIM;
    localparam int CNT_W     = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam int LAST      = (1 << LOG2_DECIM) - 1;
    localparam int RND_BIAS  = (ROUND != 0) ? ((1 << LOG2_DECIM) >> 1) : 0;

    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    logic              cnt_last;
    logic              in_ready;
    logic              accept;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  sum_rnd;

    // Only the block-completing sample has to wait for the output register to drain.
    always_comb begin
        cnt_last = (cnt == CNT_W'(LAST));
        in_ready = reset_n && !bus.flush && !(cnt_last && out_valid && !bus.out_ready);
        accept   = bus.in_valid && in_ready;
        sum      = acc + ACC_W'(bus.in_data);
        // Bias cannot overflow ACC_W: the largest sum is 2**ACC_W - 2**LOG2_DECIM.
        sum_rnd  = sum + ACC_W'(RND_BIAS);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (bus.flush) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                if (cnt_last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end

            if (accept && cnt_last) begin
                out_valid <= 1'b1;
                out_data  <= DATA_W'(sum_rnd >> LOG2_DECIM);
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
endmodule

// File: tb/tb_fixed_point_quotient_decimator.sv
// Bench for the quotient decimator: three instances (round, truncate, pass-through) checked
// every cycle against a block-averaging model, plus literal expectations on the output streams.
module tb_fixed_point_quotient_decimator;
    logic clk;
    logic rst_n;

    logic       ab_valid, ab_flush, ab_ready;
    logic [7:0] ab_data;
    logic       c_valid, c_ready;
    logic [7:0] c_data;

    int checks = 0;
    int errors = 0;

    int         m_cnt [3];
    int         m_sum [3];
    bit         m_pend[3];
    logic [7:0] m_data[3];

    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    logic [7:0] got_c[$];
    logic [7:0] sent_c[$];

    fixed_point_quotient_decimator_if #(.DATA_W(8)) bus_a ();
    fixed_point_quotient_decimator_if #(.DATA_W(8)) bus_b ();
    fixed_point_quotient_decimator_if #(.DATA_W(8)) bus_c ();

    assign bus_a.in_valid  = ab_valid;
    assign bus_a.in_data   = ab_data;
    assign bus_a.flush     = ab_flush;
    assign bus_a.out_ready = ab_ready;
    assign bus_b.in_valid  = ab_valid;
    assign bus_b.in_data   = ab_data;
    assign bus_b.flush     = ab_flush;
    assign bus_b.out_ready = ab_ready;
    assign bus_c.in_valid  = c_valid;
    assign bus_c.in_data   = c_data;
    assign bus_c.flush     = 1'b0;
    assign bus_c.out_ready = c_ready;

    fixed_point_quotient_decimator #(.DATA_W(8), .LOG2_DECIM(2), .ROUND(1)) dut_a (
        .clk(clk), .reset_n(rst_n), .bus(bus_a));
    fixed_point_quotient_decimator #(.DATA_W(8), .LOG2_DECIM(2), .ROUND(0)) dut_b (
        .clk(clk), .reset_n(rst_n), .bus(bus_b));
    fixed_point_quotient_decimator #(.DATA_W(8), .LOG2_DECIM(0), .ROUND(1)) dut_c (
        .clk(clk), .reset_n(rst_n), .bus(bus_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_sum[i]  = 0;
            m_pend[i] = 1'b0;
            m_data[i] = 8'h00;
        end
    end

    function automatic int lg_of(input int id);
        return (id == 2) ? 0 : 2;
    endfunction

    function automatic bit rnd_of(input int id);
        return (id != 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a block is a list of accepted samples; its mean is plain integer arithmetic.
    task automatic model_step(input int id, input logic v, input logic [7:0] d, input logic fl,
                              input logic ordy, input logic ir, input logic ov,
                              input logic [7:0] od);
        int n;
        int mean;
        bit exp_ir;
        bit fire;
        bit newres;
        n      = 1 << lg_of(id);
        exp_ir = rst_n && !fl && !((m_cnt[id] == n - 1) && m_pend[id] && !ordy);
        check($sformatf("in_ready[%0d]", id), {31'b0, ir}, {31'b0, exp_ir});
        check($sformatf("out_valid[%0d]", id), {31'b0, ov}, {31'b0, m_pend[id]});
        check($sformatf("out_data[%0d]", id), {24'b0, od}, {24'b0, m_data[id]});
        if (!rst_n) begin
            m_cnt[id]  = 0;
            m_sum[id]  = 0;
            m_pend[id] = 1'b0;
            m_data[id] = 8'h00;
        end else begin
            fire   = m_pend[id] && ordy;
            newres = 1'b0;
            if (fire) begin
                case (id)
                    0:       got_a.push_back(od);
                    1:       got_b.push_back(od);
                    default: got_c.push_back(od);
                endcase
            end
            if (fl) begin
                m_cnt[id] = 0;
                m_sum[id] = 0;
            end else if (v && exp_ir) begin
                m_sum[id] += int'(d);
                m_cnt[id] += 1;
                if (m_cnt[id] == n) begin
                    mean       = (m_sum[id] + ((rnd_of(id) && n > 1) ? n / 2 : 0)) / n;
                    m_data[id] = mean[7:0];
                    newres     = 1'b1;
                    m_cnt[id]  = 0;
                    m_sum[id]  = 0;
                end
            end
            m_pend[id] = newres ? 1'b1 : (fire ? 1'b0 : m_pend[id]);
        end
    endtask

    always @(negedge clk) begin
        model_step(0, ab_valid, ab_data, ab_flush, ab_ready,
                   bus_a.in_ready, bus_a.out_valid, bus_a.out_data);
        model_step(1, ab_valid, ab_data, ab_flush, ab_ready,
                   bus_b.in_ready, bus_b.out_valid, bus_b.out_data);
        model_step(2, c_valid, c_data, 1'b0, c_ready,
                   bus_c.in_ready, bus_c.out_valid, bus_c.out_data);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_ab(input logic [7:0] d);
        int budget;
        budget   = 0;
        ab_valid = 1'b1;
        ab_data  = d;
        @(negedge clk);
        while (!bus_a.in_ready && budget < 50) begin
            budget++;
            @(negedge clk);
        end
        if (budget >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_ab_timeout actual=stalled required=accepted data=%0h", d);
        end
        @(posedge clk);
        #1;
        ab_valid = 1'b0;
    endtask

    task automatic send_c(input logic [7:0] d, input bit rand_ready);
        int  budget;
        bit  taken;
        budget  = 0;
        taken   = 1'b0;
        c_valid = 1'b1;
        c_data  = d;
        sent_c.push_back(d);
        while (!taken && budget < 50) begin
            if (rand_ready) c_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            taken = bus_c.in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL send_c_timeout actual=stalled required=accepted data=%0h", d);
        end
        c_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_a[6];
        logic [7:0] exp_b[6];
        rst_n    = 1'b0;
        ab_valid = 1'b0;
        ab_flush = 1'b0;
        ab_ready = 1'b0;
        ab_data  = 8'h00;
        c_valid  = 1'b0;
        c_ready  = 1'b0;
        c_data   = 8'h00;

        @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'b0, bus_a.in_ready}, 32'd0);
        check("reset_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        check("reset_out_data", {24'b0, bus_a.out_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ab_ready = 1'b1;
        c_ready  = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'b0, bus_a.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic mean, round vs truncate
        send_ab(8'h10); send_ab(8'h11); send_ab(8'h12); send_ab(8'h13);
        idle(3);
        // Full-scale block must not wrap
        repeat (4) send_ab(8'hFF);
        idle(3);

        // Backpressure: completing sample of the second block waits
        ab_ready = 1'b0;
        send_ab(8'h20); send_ab(8'h22); send_ab(8'h24); send_ab(8'h26);
        idle(2);
        send_ab(8'h01); send_ab(8'h02); send_ab(8'h03);
        ab_valid = 1'b1;
        ab_data  = 8'h05;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {31'b0, bus_a.in_ready}, 32'd0);
            check("stall_out_data", {24'b0, bus_a.out_data}, 32'h23);
        end
        @(posedge clk);
        #1;
        ab_ready = 1'b1;
        send_ab(8'h05);
        idle(4);

        // Flush discards the partial block and refuses the sample presented with it
        send_ab(8'h40); send_ab(8'h40);
        ab_valid = 1'b1;
        ab_data  = 8'h80;
        ab_flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'b0, bus_a.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        ab_flush = 1'b0;
        ab_valid = 1'b0;
        repeat (4) send_ab(8'h08);
        idle(3);

        // Reset with a pending mean and a partial block
        ab_ready = 1'b0;
        repeat (4) send_ab(8'h30);
        send_ab(8'h70); send_ab(8'h70);
        @(negedge clk);
        check("pre_reset_out_valid", {31'b0, bus_a.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        check("mid_reset_out_data", {24'b0, bus_a.out_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ab_ready = 1'b1;
        send_ab(8'h04); send_ab(8'h08); send_ab(8'h0C); send_ab(8'h12);
        idle(3);

        // Pass-through instance: random data and random out_ready, then full rate
        for (int i = 0; i < 40; i++) send_c(8'($urandom_range(0, 255)), 1'b1);
        c_ready = 1'b1;
        idle(2);
        for (int i = 0; i < 8; i++) begin
            c_valid = 1'b1;
            c_data  = 8'($urandom_range(0, 255));
            sent_c.push_back(c_data);
            @(negedge clk);
            check("full_rate_in_ready", {31'b0, bus_c.in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        c_valid = 1'b0;
        idle(4);

        exp_a = '{8'h12, 8'hFF, 8'h23, 8'h03, 8'h08, 8'h0B};
        exp_b = '{8'h11, 8'hFF, 8'h23, 8'h02, 8'h08, 8'h0A};
        check("stream_a_count", got_a.size(), 32'd6);
        check("stream_b_count", got_b.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_a.size()) check($sformatf("stream_a[%0d]", i), {24'b0, got_a[i]}, {24'b0, exp_a[i]});
            if (i < got_b.size()) check($sformatf("stream_b[%0d]", i), {24'b0, got_b[i]}, {24'b0, exp_b[i]});
        end
        check("stream_c_count", got_c.size(), sent_c.size());
        for (int i = 0; i < sent_c.size(); i++) begin
            if (i < got_c.size()) check($sformatf("stream_c[%0d]", i), {24'b0, got_c[i]}, {24'b0, sent_c[i]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
